// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
package gate_chk_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned SETTLE_W    = 8;
    localparam int unsigned VEC_W       = 2;
    localparam int unsigned ERR_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } chk_state_t;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Bus between the checker, the gate under test and the status consumer.
interface gate_vector_checker_if;
    import gate_chk_pkg::*;

    logic             start;
    logic             dut_c;
    logic             dut_a;
    logic             dut_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] fail_vec;
    logic             fail_valid;

    // Checker side.
    modport master (
        input  start,
        input  dut_c,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output fail_valid
    );

    // Environment side: gate under test plus start/status logic.
    modport slave (
        output start,
        output dut_c,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  fail_valid
    );

endinterface

// File: rtl/gate_chk_settle_timer.sv
// Loadable down-counter; expired is a registered copy of (count == 0).
module gate_chk_settle_timer
    import gate_chk_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            expired <= 1'b1;
        end else if (load) begin
            cnt     <= load_val;
            expired <= (load_val == '0);
        end else if (cnt != '0) begin
            cnt     <= cnt - SETTLE_W'(1);
            expired <= (cnt == SETTLE_W'(1));
        end
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Drives all four input vectors into a two-input gate, checks each response
// against TRUTH_TABLE and reports pass, error count and first failing vector.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter logic [NUM_VECTORS-1:0] TRUTH_TABLE   = 4'b1000,
    parameter int unsigned            SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_vector_checker_if.master bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]    LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    chk_state_t       state, state_d;
    logic [VEC_W-1:0] vec, vec_d;
    logic [ERR_W-1:0] err_d;
    logic [VEC_W-1:0] fail_vec_d;
    logic             fail_valid_d;
    logic [1:0]       ab_d;
    logic             busy_d, done_d, pass_d;
    logic             load_c;
    logic             expired;
    logic             mismatch_c;

    gate_chk_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .load_val (SETTLE_LOAD),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state plus next value of every result register.
    always_comb begin
        state_d      = state;
        vec_d        = vec;
        err_d        = bus.err_count;
        fail_vec_d   = bus.fail_vec;
        fail_valid_d = bus.fail_valid;
        ab_d         = {bus.dut_a, bus.dut_b};
        load_c       = 1'b0;
        mismatch_c   = (bus.dut_c != TRUTH_TABLE[vec]);

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = DRIVE;
                    vec_d        = '0;
                    err_d        = '0;
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
                end
            end
            DRIVE: begin
                ab_d    = vec;
                load_c  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (expired) state_d = CHECK;
            end
            CHECK: begin
                if (mismatch_c) begin
                    err_d = bus.err_count + ERR_W'(1);
                    if (!bus.fail_valid) begin
                        fail_vec_d   = vec;
                        fail_valid_d = 1'b1;
                    end
                end
                if (vec == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec + VEC_W'(1);
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec            <= '0;
            bus.dut_a      <= 1'b0;
            bus.dut_b      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.err_count  <= '0;
            bus.fail_vec   <= '0;
            bus.fail_valid <= 1'b0;
        end else begin
            vec            <= vec_d;
            bus.dut_a      <= ab_d[1];
            bus.dut_b      <= ab_d[0];
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.pass       <= pass_d;
            bus.err_count  <= err_d;
            bus.fail_vec   <= fail_vec_d;
            bus.fail_valid <= fail_valid_d;
        end
    end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking hardware stimulus/response engine for single-output, two-input combinational gates on the iceBlinkPico fabric. It drives the four input vectors 00, 01, 10 and 11 into a device under test (DUT) and waits a programmable settle time after each one. It then samples the DUT output and compares it against a parameterised truth table. At the end it reports pass/fail, an error count and the first failing vector. It sits between the DUT and the board status LEDs, replacing simulation-only test vectors with an on-chip check.

## Interface
Parameters:
- `TRUTH_TABLE`, default 4'b1000: expected output, indexed by `{a,b}`; the default is AND.
- `SETTLE_CYCLES`, default 4: clock cycles held in SETTLE per vector; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled each cycle; begins a run when sampled high in IDLE or DONE.
- `dut_c`  in  1  DUT output; same clock domain, sampled directly.
- `dut_a`  out  1  registered DUT input a, equal to `vec[1]`.
- `dut_b`  out  1  registered DUT input b, equal to `vec[0]`.
- `busy`  out  1  high in DRIVE, SETTLE and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid only while `done`=1; equals (`err_count`==0).
- `err_count`  out  3  number of mismatches in the current or last run, 0..4.
- `fail_vec`  out  2  `{a,b}` of the first mismatch.
- `fail_valid`  out  1  high once a mismatch has been recorded in this run.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE. Internal `vec` is 2 bits; internal `settle_cnt` is 8 bits.
- IDLE, with `start`=1 → DRIVE. On that edge:
  - `vec`←0, `err_count`←0, `fail_valid`←0, `fail_vec`←0.
- DRIVE (1 cycle):
  - `dut_a`,`dut_b`←`vec`; `settle_cnt`←`SETTLE_CYCLES`-1; → SETTLE.
- SETTLE:
  - If `settle_cnt`==0 → CHECK; otherwise decrement.
  - Total dwell is exactly `SETTLE_CYCLES` cycles.
- CHECK (1 cycle): compare `dut_c` with `TRUTH_TABLE[vec]`.
  - On mismatch: `err_count`+1.
  - If `fail_valid`=0: `fail_vec`←`vec` and `fail_valid`←1.
  - If `vec`==3 → DONE; otherwise `vec`+1 and → DRIVE.
- DONE:
  - Results held stable.
  - `start`=1 → DRIVE, with the same clears as from IDLE (re-run).
- Boundary rules:
  - `start` is ignored while `busy`=1.
  - `vec` never wraps inside a run; the 3→0 transition happens only on a new start.
  - `err_count` maximum is 4, so 3 bits need no saturation.
  - `dut_a`/`dut_b` keep their last value in DONE and are 0 in IDLE.
- Reset, any time, including mid-run:
  - State → IDLE.
  - All outputs → 0: `dut_a`, `dut_b`, `busy`, `done`, `pass`, `err_count`, `fail_vec`, `fail_valid`.
  - `vec` and `settle_cnt` → 0.
  - After reset is released, no run starts until `start` is sampled high.

## Timing
- Per vector: DRIVE (1) + SETTLE (S) + CHECK (1) = S+2 cycles, where S = `SETTLE_CYCLES`.
- Full run: `busy` is high for 4(S+2) cycles.
  - If `start` is sampled at edge k, `busy` rises after edge k and `done` rises after edge k+4(S+2).
  - With S=4: `done` rises after edge k+24.
- Settle time: DUT inputs change after the DRIVE edge, so `dut_c` gets S+1 full cycles before the CHECK edge samples it.
- Outputs:
  - All outputs are registered; no combinational path from `dut_c` or `start` to any output.
  - `err_count`/`fail_*` update on the edge that leaves CHECK.
  - `pass` is updated on entry to DONE.

## Structure
- Shared package `gate_chk_pkg`:
  - state enum `chk_state_t` (IDLE, DRIVE, SETTLE, CHECK, DONE);
  - constant `NUM_VECTORS`=4;
  - constant `SETTLE_W`=8.
- One sub-module, `gate_chk_settle_timer`:
  - inputs: load and load value;
  - output: `expired`;
  - an 8-bit down-counter with asynchronous active-low reset.
- The FSM, vector register and result registers live in `gate_vector_checker`.

## Test plan
- Correct AND DUT, defaults, `start` pulsed for 1 cycle:
  - vectors 00, 01, 10, 11 appear, each held 6 cycles;
  - `done`=1 after edge k+24, `pass`=1, `err_count`=0, `fail_valid`=0.
- DUT forced to constant 1:
  - mismatches at 00, 01 and 10;
  - `err_count`=3, `fail_vec`=2'b00, `fail_valid`=1, `pass`=0.
- DUT implemented as OR with `TRUTH_TABLE`=4'b1110:
  - `pass`=1.
- Same OR DUT with the default `TRUTH_TABLE`:
  - `err_count`=2, `fail_vec`=2'b01.
- `rst_n` pulled low during SETTLE of vector 10:
  - all outputs read 0 immediately, state is IDLE;
  - after release with `start`=0 for 20 cycles, `busy` stays 0.
- `start` held high for an entire run:
  - no restart while busy;
  - DONE is entered, and on the next edge the block re-enters DRIVE with `err_count` cleared and `vec`=0.
- `SETTLE_CYCLES`=1:
  - each vector lasts 3 cycles; `done` rises after edge k+12.
